// File: rtl/unet_pvm_mac_pipe.sv
// Pipelined signed x unsigned multiply-accumulate with valid/ready backpressure.
// Define UNET_PVM_MAC_SAT_EN to saturate the accumulator and enable the sticky sat_flag.
`timescale 1ns/1ps
module unet_pvm_mac_pipe #(
    parameter int DIN0_WIDTH = 18,
    parameter int DIN1_WIDTH = 8,
    parameter int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_STAGE  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  acc_en,
    input  logic                  in_first,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  dout,
    output logic                  sat_flag
);

    typedef struct packed {
        logic                  valid;
        logic                  acc_en;
        logic                  first;
        logic                  last;
        logic [PROD_WIDTH-1:0] prod;
    } beat_t;

    logic                  advance;
    logic [PROD_WIDTH-1:0] a_ext;
    logic [PROD_WIDTH-1:0] b_ext;
    beat_t                 beat_in;
    beat_t                 stage_q [NUM_STAGE];
    beat_t                 tail;

    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [ACC_WIDTH-1:0]  dout_q, dout_d;
    logic                  out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]  acc_base;
    logic [ACC_WIDTH-1:0]  acc_next;

    // Every register in the pipe freezes together whenever the output is held.
    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    // The true product always fits PROD_WIDTH bits, so a modular multiply of the
    // sign-/zero-extended operands yields the exact two's-complement result.
    assign a_ext = PROD_WIDTH'($signed(din0));
    assign b_ext = PROD_WIDTH'(din1);

    always_comb begin
        beat_in.valid  = in_valid;
        beat_in.acc_en = acc_en;
        beat_in.first  = in_first;
        beat_in.last   = in_last;
        beat_in.prod   = a_ext * b_ext;
    end

    // NOTE: pipeline data is reset along with the tags so a reset leaves no stale state anywhere.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STAGE; i++) stage_q[i] <= '0;
        end else if (advance) begin
            // NOTE: non-blocking assignments let every stage shift from its pre-edge neighbour.
            stage_q[0] <= beat_in;
            for (int i = 1; i < NUM_STAGE; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tail     = stage_q[NUM_STAGE-1];
    assign prod_ext = ACC_WIDTH'($signed(tail.prod));
    assign acc_base = tail.first ? '0 : acc_q;

`ifdef UNET_PVM_MAC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0] sum_wide;
    logic               ovf;
    logic               sat_q, sat_d;

    assign sum_wide = {acc_base[ACC_WIDTH-1], acc_base} + {prod_ext[ACC_WIDTH-1], prod_ext};
    assign ovf      = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
    assign acc_next = ovf ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum_wide[ACC_WIDTH-1:0];
    assign sat_flag = sat_q;
`else
    assign acc_next = acc_base + prod_ext;
    assign sat_flag = 1'b0;
`endif

    // NOTE: every always_comb output gets a hold default first, so no latch is inferred.
    always_comb begin
        acc_d       = acc_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
`ifdef UNET_PVM_MAC_SAT_EN
        sat_d       = sat_q;
`endif
        if (advance) begin
            out_valid_d = 1'b0;
            if (tail.valid) begin
                if (!tail.acc_en) begin
                    dout_d      = prod_ext;
                    out_valid_d = 1'b1;
                end else begin
                    acc_d = acc_next;
`ifdef UNET_PVM_MAC_SAT_EN
                    sat_d = (tail.first ? 1'b0 : sat_q) | ovf;
`endif
                    if (tail.last) begin
                        dout_d      = acc_next;
                        out_valid_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef UNET_PVM_MAC_SAT_EN
            sat_q       <= 1'b0;
`endif
        end else begin
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
`ifdef UNET_PVM_MAC_SAT_EN
            sat_q       <= sat_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_unet_pvm_mac_pipe.sv
// Scoreboard bench for unet_pvm_mac_pipe: a 32-bit and a 26-bit accumulator instance share stimulus.
// Expected saturation results follow UNET_PVM_MAC_SAT_EN.
`timescale 1ns/1ps
module tb_unet_pvm_mac_pipe;

`ifdef UNET_PVM_MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic in_valid, acc_en, in_first, in_last, out_ready;
    logic [17:0] din0;
    logic [7:0]  din1;
    logic in_ready_32, in_ready_26, out_valid_32, out_valid_26, sat_32, sat_26;
    logic signed [31:0] dout_32;
    logic signed [25:0] dout_26;

    always #5 clk = ~clk;

    unet_pvm_mac_pipe #(.ACC_WIDTH(32)) dut_32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_32),
        .din0(din0), .din1(din1), .acc_en(acc_en), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_32), .out_ready(out_ready), .dout(dout_32), .sat_flag(sat_32)
    );

    unet_pvm_mac_pipe #(.ACC_WIDTH(26)) dut_26 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_26),
        .din0(din0), .din1(din1), .acc_en(acc_en), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_26), .out_ready(out_ready), .dout(dout_26), .sat_flag(sat_26)
    );

    typedef struct {
        int d32;
        int d26;
        bit s26;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void expect_out(input int d32, input int d26, input bit s26);
        exp_t e;
        e.d32 = d32;
        e.d26 = d26;
        e.s26 = s26;
        sb_q.push_back(e);
    endfunction

    // Monitor: pops one expected result per output handshake.
    initial begin
        logic               held_valid;
        logic signed [31:0] held;
        exp_t               e;
        held_valid = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                held_valid = 1'b0;
            end else begin
                if (held_valid && out_valid_32) check("dout_stable_in_stall", dout_32, held);
                held_valid = out_valid_32 && !out_ready;
                held       = dout_32;
                if (out_valid_32 && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=%0d expected=none", dout_32);
                    end else begin
                        e = sb_q.pop_front();
                        check("dout_32", dout_32, e.d32);
                        check("dout_26", dout_26, e.d26);
                        check("out_valid_26", out_valid_26, 1);
                        check("sat_26", sat_26, e.s26);
                        check("sat_32", sat_32, 0);
                    end
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input int a, input int b, input bit acc, input bit first, input bit last);
        int n;
        n        = 0;
        din0     = a[17:0];
        din1     = b[7:0];
        acc_en   = acc;
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready_32) begin
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=in_ready_low required=accept_within_200");
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!out_valid_32 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, out_valid_32, 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        acc_en    = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        din0      = '0;
        din1      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid_32, 0);
        check("rst_dout", dout_32, 0);
        check("rst_sat_26", sat_26, 0);
        check("rst_in_ready", in_ready_32, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single pass-through with exact latency and a one-cycle pulse
        expect_out(-600, -600, 1'b0);
        send(-3, 200, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("pt_out_valid_t%0d", k), out_valid_32, (k == 4) ? 1 : 0);
        end
        drain("drain_pt");

        // Burst of four beats, single result
        send(100, 255, 1'b1, 1'b1, 1'b0);
        send(-50, 2, 1'b1, 1'b0, 1'b0);
        send(7, 7, 1'b1, 1'b0, 1'b0);
        expect_out(25448, 25448, 1'b0);
        send(-1, 1, 1'b1, 1'b0, 1'b1);
        drain("drain_burst");

        // Pass-through interleaved mid-burst leaves accumulator intact
        send(10, 10, 1'b1, 1'b1, 1'b0);
        expect_out(9, 9, 1'b0);
        send(3, 3, 1'b0, 1'b0, 1'b0);
        expect_out(110, 110, 1'b0);
        send(2, 5, 1'b1, 1'b0, 1'b1);
        drain("drain_interleave");

        // Abandoned burst: a new first discards the running sum
        send(9, 9, 1'b1, 1'b1, 1'b0);
        expect_out(4, 4, 1'b0);
        send(2, 2, 1'b1, 1'b1, 1'b1);
        drain("drain_abandon");

        // Operand extremes
        expect_out(-33423360, -33423360, 1'b0);
        send(-131072, 255, 1'b0, 1'b0, 1'b0);
        expect_out(33423105, 33423105, 1'b0);
        send(131071, 255, 1'b0, 1'b0, 1'b0);
        drain("drain_extremes");

        // Backpressure: six streamed beats, output stalled five cycles mid-stream
        fork
            begin
                expect_out(1, 1, 1'b0);             send(1, 1, 1'b0, 1'b0, 1'b0);
                expect_out(-6, -6, 1'b0);           send(-2, 3, 1'b0, 1'b0, 1'b0);
                expect_out(100000, 100000, 1'b0);   send(1000, 100, 1'b0, 1'b0, 1'b0);
                expect_out(-1785, -1785, 1'b0);     send(-7, 255, 1'b0, 1'b0, 1'b0);
                expect_out(209865, 209865, 1'b0);   send(12345, 17, 1'b0, 1'b0, 1'b0);
                expect_out(-131072, -131072, 1'b0); send(-131072, 1, 1'b0, 1'b0, 1'b0);
            end
            begin
                wait_out_valid("bp_first_out");
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready_stalled", in_ready_32, 0);
                    check("bp_out_valid_held", out_valid_32, 1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Overflow on the 26-bit instance
        expect_out(66846210, SAT ? 33554431 : -262654, SAT);
        send(131071, 255, 1'b1, 1'b1, 1'b0);
        send(131071, 255, 1'b1, 1'b0, 1'b1);
        drain("drain_overflow");

        // Reset mid-burst with the output stalled
        out_ready = 1'b0;
        send(11, 11, 1'b1, 1'b1, 1'b0);
        send(12, 12, 1'b1, 1'b0, 1'b0);
        send(4, 4, 1'b0, 1'b0, 1'b0);
        wait_out_valid("rst_pre_out_valid");
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_out_valid_32", out_valid_32, 0);
        check("rst_mid_out_valid_26", out_valid_26, 0);
        check("rst_mid_dout_32", dout_32, 0);
        check("rst_mid_dout_26", dout_26, 0);
        check("rst_mid_sat_26", sat_26, 0);
        check("rst_mid_in_ready", in_ready_32, 1);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_out(20, 20, 1'b0);
        send(5, 4, 1'b1, 1'b1, 1'b1);
        drain("drain_post_reset");

        // first=0 right after reset accumulates onto zero
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expect_out(36, 36, 1'b0);
        send(6, 6, 1'b1, 1'b0, 1'b1);
        drain("drain_no_first");

        repeat (5) @(posedge clk);
        check("sb_empty_end", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unet_pvm_mac_pipe.md
Name: unet_pvm_mac_pipe

Overview:
Pipelined, parametrised signed×unsigned multiply-accumulate for the UNet PVM datapath. It replaces the fixed 18s×8ns combinational multiplier with a configurable-latency multiplier, valid/ready backpressure, an optional per-burst accumulator and optional output saturation. It sits between the feature/weight stream readers and the conv-layer result writer.

Parameters:
DIN0_WIDTH, 18, signed operand width (activation)
DIN1_WIDTH, 8, unsigned operand width (weight magnitude), zero-extended by 1 bit before multiply
PROD_WIDTH, DIN0_WIDTH+DIN1_WIDTH, full product width, never truncated
ACC_WIDTH, 32, accumulator/output width, ≥ PROD_WIDTH
NUM_STAGE, 3, multiplier register stages, legal range 1..4

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
din0  in  DIN0_WIDTH  signed operand
din1  in  DIN1_WIDTH  unsigned operand
acc_en  in  1  1 = beat belongs to an accumulation burst; 0 = pass product through
in_first  in  1  first beat of burst (acc_en=1 only): accumulator loads instead of adds
in_last  in  1  last beat of burst (acc_en=1 only): result emitted
out_valid  out  1  result valid
out_ready  in  1  downstream accepts when out_valid && out_ready
dout  out  ACC_WIDTH  signed result
sat_flag  out  1  sticky saturation indicator (see Optional Feature)

Behaviour:
- Global-stall pipeline: advance = !out_valid || out_ready; in_ready = advance (combinational, no dependence on in_valid).
- Product = $signed(din0) * $signed({1'b0,din1}), PROD_WIDTH bits, sign-extended to ACC_WIDTH at accumulator stage.
- Stages: NUM_STAGE multiplier registers, each carrying valid, acc_en, first, last tags; then one accumulate/output register. All registers hold while advance=0.
- Latency: beat accepted at cycle T with output unstalled -> out_valid at T+NUM_STAGE+1 (non-acc beat, or last beat of burst). Throughput 1 beat/cycle.
- Accumulate stage, valid beat:
  - acc_en=0: dout <= sext(prod); out_valid<=1; accumulator unchanged.
  - acc_en=1, first=1: acc <= sext(prod); else acc <= acc + sext(prod) (ACC_WIDTH wrap without macro).
  - acc_en=1, last=1: dout <= new acc value, out_valid<=1. first&&last: dout = product.
  - acc_en=1, last=0: no output; out_valid cleared if it was consumed this cycle.
- Output register: out_valid cleared when out_valid && out_ready and no new result loads; dout held while out_valid && !out_ready.
- Interleaving: acc_en=0 beats may arrive mid-burst; they emit and leave the accumulator intact.
- New first=1 without prior last discards the running accumulator (no output for abandoned burst).
- first=0 after reset accumulates onto 0.
- Reset (any time, incl. mid-burst or mid-stall): all valid tags 0, acc 0, dout 0, out_valid 0, sat_flag 0; in_ready reads 1. In-flight beats are lost.
- Inputs in_first/in_last/acc_en are ignored when in_valid=0.

Optional Feature:
Macro UNET_PVM_MAC_SAT_EN.
- Defined: accumulator add and load saturate to signed ACC_WIDTH max (2^(ACC_WIDTH-1)-1) / min (-2^(ACC_WIDTH-1)); sat_flag set when saturation occurs, cleared only by reset or by a first=1 beat reaching the accumulator stage.
- Undefined: two's-complement wrap; sat_flag tied 0; no extra logic.

Test Plan:
- Single pass-through: acc_en=0, din0=-3, din1=200, out_ready=1 -> dout=-600, out_valid exactly at T+4 (NUM_STAGE=3), one cycle wide.
- Burst: (100,255,first),(-50,2),(7,7),(-1,1,last), acc_en=1 -> single output dout=25448; no out_valid on first three beats.
- Backpressure: 6 consecutive acc_en=0 beats, out_ready low 5 cycles mid-stream -> in_ready low while stalled, all 6 products delivered in order, none duplicated or lost, dout stable during stall.
- Extremes: din0=-131072, din1=255 -> dout=-33423360; din0=131071, din1=255 -> 33423105.
- Overflow, ACC_WIDTH=26: two beats 131071×255 (first, last) -> with UNET_PVM_MAC_SAT_EN dout=33554431, sat_flag=1; without it dout=-262654, sat_flag=0.
- Reset mid-burst: assert reset after 2 of 4 burst beats while out_ready=0 -> out_valid/dout/sat_flag 0 immediately; new first/last burst (5,4) afterwards -> dout=20, no residue from the aborted burst.
